// File: rtl/niosii_system_nios2_0_jtag_debug_master.sv
`timescale 1ns/1ps
// JTAG host engine for the virtual-JTAG side of the Nios II debug module.
// One command produces one complete UIR/CDR/SDR/UDR/RTI sequence with a
// divided-down tck; the captured tdo stream is returned as a response.
//
// Handshakes: a transfer happens on a clk edge where valid and ready are
// both high. cmd_valid may be raised or dropped at any time and is only
// looked at while cmd_ready is high. rsp_valid, once raised, stays high with
// rsp_dr/rsp_ir_out frozen until the edge where rsp_ready is seen high.
module niosii_system_nios2_0_jtag_debug_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [2:0]          dbg_state
);

  // A divider of 1 needs no half-period counter; keep a 1-bit one that sits at 0.
  localparam int HC_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BC_W = $clog2(DR_WIDTH);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(TCK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_UDR  = 3'd4,
    S_RTI  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [HC_W-1:0]     half_cnt;
  logic [BC_W-1:0]     bit_cnt;
  logic                tck_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic [DR_WIDTH-1:0] shift_q;
  logic [DR_WIDTH-1:0] capture_q;

  logic scanning;
  logic half_end;
  logic tck_rise;
  logic tck_fall;
  logic accept;
  logic last_bit;

  // tck only runs while a scan state is active; it is parked low otherwise.
  assign scanning = (state != S_IDLE) && (state != S_DONE);
  assign half_end = scanning && (half_cnt == HC_LAST);
  // These flag the clk edge on which tck toggles, not the tck level itself.
  assign tck_rise = half_end && !tck_q;
  assign tck_fall = half_end && tck_q;
  assign accept   = (state == S_IDLE) && cmd_valid;
  assign last_bit = (bit_cnt == BC_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and strobe decode; state only moves on a tck falling edge,
  // so every strobe is stable around the following rising edge.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    vji_uir   = 1'b0;
    vji_cdr   = 1'b0;
    vji_sdr   = 1'b0;
    vji_udr   = 1'b0;
    vji_rti   = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_UIR;
      end
      S_UIR: begin
        vji_uir = 1'b1;
        if (tck_fall) state_nxt = S_CDR;
      end
      S_CDR: begin
        vji_cdr = 1'b1;
        if (tck_fall) state_nxt = S_SDR;
      end
      S_SDR: begin
        vji_sdr = 1'b1;
        if (tck_fall && last_bit) state_nxt = S_UDR;
      end
      S_UDR: begin
        vji_udr = 1'b1;
        if (tck_fall) state_nxt = S_RTI;
      end
      S_RTI: begin
        vji_rti = 1'b1;
        if (tck_fall) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // tck generator: TCK_DIV clk cycles low, then TCK_DIV cycles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tck_q    <= 1'b0;
      half_cnt <= '0;
    end else if (!scanning) begin
      tck_q    <= 1'b0;
      half_cnt <= '0;
    end else if (half_end) begin
      tck_q    <= ~tck_q;
      half_cnt <= '0;
    end else begin
      half_cnt <= half_cnt + HC_W'(1);
    end
  end

  // Command latch and outgoing shift register; advances after each SDR bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q    <= '0;
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      ir_q    <= cmd_ir;
      shift_q <= cmd_dr;
      bit_cnt <= '0;
    end else if ((state == S_SDR) && tck_fall) begin
      shift_q <= shift_q >> 1;
      bit_cnt <= last_bit ? '0 : bit_cnt + BC_W'(1);
    end
  end

  // Capture tdo into the MSB at each SDR rising edge so the first bit ends in bit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_q <= '0;
    end else if (accept) begin
      capture_q <= '0;
    end else if ((state == S_SDR) && tck_rise) begin
      capture_q <= {vji_tdo, capture_q[DR_WIDTH-1:1]};
    end
  end

  // Response registers: ir_out sampled in UDR, data published one cycle into DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= 1'b0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
    end else begin
      if ((state == S_UDR) && tck_rise) begin
        rsp_ir_out <= vji_ir_out;
      end
      if (state == S_DONE) begin
        if (!rsp_valid) begin
          rsp_valid <= 1'b1;
          rsp_dr    <= capture_q;
        end else if (rsp_ready) begin
          rsp_valid <= 1'b0;
        end
      end
    end
  end

  assign vji_tck   = tck_q;
  assign vji_tdi   = (state == S_SDR) ? shift_q[0] : 1'b0;
  assign vji_ir_in = ir_q;
  assign dbg_state = state;

endmodule

// File: doc/niosii_system_nios2_0_jtag_debug_master.md
# niosII_system_nios2_0_jtag_debug_master

System-clock-domain JTAG host engine that drives the virtual-JTAG side of the Nios II debug module: it issues one IR/DR scan per command, generating tck, tdi and the uir/cdr/sdr/udr/rti state strobes, and captures the responder's tdo stream. It lets on-chip logic and simulation benches exercise the debug module's tck/sysclk path without a physical JTAG hub, acting as the initiator end of the same scan protocol.

## Interface
Parameters:
- DR_WIDTH, 38, data-register scan length in bits (≥2)
- IR_WIDTH, 2, instruction width
- TCK_DIV, 2, clk cycles per tck half-period (≥1)

Ports:
- clk  in  1  system clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_ir  in  IR_WIDTH  instruction for this scan
- cmd_dr  in  DR_WIDTH  data shifted in, LSB first
- rsp_valid  out  1  scan result available
- rsp_ready  in  1  result consumed
- rsp_dr  out  DR_WIDTH  bits captured from tdo, first bit in bit 0
- rsp_ir_out  out  IR_WIDTH  responder ir_out, sampled in UDR
- vji_tck  out  1  generated test clock
- vji_tdi  out  1  serial data to responder
- vji_tdo  in  1  serial data from responder
- vji_ir_in  out  IR_WIDTH  instruction presented to responder
- vji_ir_out  in  IR_WIDTH  responder instruction status
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes

## Operation
- States: IDLE → UIR → CDR → SDR → UDR → RTI → DONE → IDLE.
- IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch cmd_ir into vji_ir_in and cmd_dr into shift register; go UIR.
- Each of UIR, CDR, UDR, RTI lasts exactly one tck period; SDR lasts exactly DR_WIDTH tck periods; matching strobe high for the whole state, all others low.
- vji_ir_in held from UIR through DONE; returns to 0 only on reset (holds last value in IDLE).
- SDR: vji_tdi = shift register bit 0; at each tck rising edge sample vji_tdo into capture register MSB and shift capture register right; shift out register right at each tck falling edge. After DR_WIDTH bits rsp_dr bit 0 = first tdo sampled.
- vji_tdi = 0 outside SDR.
- UDR: rsp_ir_out sampled at the tck rising edge.
- DONE: rsp_valid=1, rsp_dr/rsp_ir_out stable until rsp_valid&rsp_ready; then IDLE. cmd_ready stays 0 during DONE (no overlap).
- cmd_valid deasserted mid-scan has no effect; scan always completes.

## Timing
- tck period = 2·TCK_DIV clk cycles: low TCK_DIV cycles, then high TCK_DIV cycles; tck stays 0 in IDLE and DONE; first period starts low in the cycle after acceptance.
- All strobes, vji_tdi and state change only coincident with a tck falling edge (or tck-low start), so they are stable around every rising edge.
- tdo/ir_out sampled on the clk edge where vji_tck goes 0→1 (value present before the rising edge).
- Latency: command accepted at clk edge 0 → rsp_valid high after edge 2·TCK_DIV·(DR_WIDTH+4)+1; 169 cycles for defaults.
- rsp_ready high while rsp_valid → rsp_valid low and cmd_ready high next cycle; back-to-back command accepted that cycle earliest.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_dr=0, rsp_ir_out=0, vji_tck=0, vji_tdi=0, vji_ir_in=0, all strobes 0, state IDLE.
- Reset mid-scan: all outputs to reset values immediately (asynchronous), partial capture discarded, no rsp_valid.
- Counters: half-period counter ceil(log2(TCK_DIV)) bits, bit counter ceil(log2(DR_WIDTH)) bits; terminal counts TCK_DIV−1 and DR_WIDTH−1; no wrap beyond.

## Test plan
- Loopback responder model (sr captures 38'h3F_0000_FFFF on cdr, sr={tdi,sr[37:1]} on rising tck, tdo=sr[0]); cmd_ir=2'b01, cmd_dr=38'h2A_5555_AAAA → rsp_dr=38'h3F_0000_FFFF, responder sr at udr = 38'h2A_5555_AAAA, vji_ir_in=2'b01 throughout, rsp_valid at cycle 169.
- Strobe sequencing check, TCK_DIV=1: uir, cdr each 2 cycles, sdr 76 cycles, udr, rti 2 cycles each, never two high together; tck low in IDLE; rsp_valid at cycle 85.
- rsp_ready held low 20 cycles → rsp_valid and rsp_dr stable, cmd_ready=0, tck idle; second cmd_valid ignored until release.
- Back-to-back: two commands (dr 38'h0 then 38'h3F_FFFF_FFFF), rsp_ready tied 1 → second accepted the cycle after first rsp handshake; responder sees each value exactly.
- reset_n pulsed low in SDR bit 10 → all outputs at reset values within same cycle, cmd_ready=1 after release, next scan completes correctly.
- ir_out model returns 2'b10 → rsp_ir_out=2'b10; changing it after UDR does not alter rsp_ir_out.
